// File: rtl/barrier_damage_if.sv
// barrier_damage_if
// Hit-request and damage-output bundle between the shot/collision logic
// (master) and barrier_damage_arbiter (slave).
//
// Handshake: requester i transfers one hit on any rising clk edge where
// req_valid[i] & req_ready[i]. The requester must keep req_x/req_y
// stable while req_valid is high. req_ready may drop without a transfer.
// There is no back-pressure on the damage side. new_damage is a one-cycle
// strobe, and damage_x/damage_y/grant_id are valid while it is high.
//
// Signals:
//   req_valid  [NUM_REQ]          per-requester hit valid
//   req_x      [NUM_REQ*COORD_W]  packed hit x, requester i at [i*COORD_W +: COORD_W]
//   req_y      [NUM_REQ*COORD_W]  packed hit y, same packing
//   req_ready  [NUM_REQ]          requester i may present a hit
//   damage_x   [COORD_W]          x of the issued hit
//   damage_y   [COORD_W]          y of the issued hit
//   new_damage                    one-cycle damage strobe
//   grant_id   [ID_W]             source of the current or last pulse
interface barrier_damage_if #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 11,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ-1:0]         req_ready;
  logic [COORD_W-1:0]         damage_x;
  logic [COORD_W-1:0]         damage_y;
  logic                       new_damage;
  logic [ID_W-1:0]            grant_id;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, damage_x, damage_y, new_damage, grant_id
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, damage_x, damage_y, new_damage, grant_id
  );
endinterface

// File: rtl/barrier_damage_arbiter.sv
// barrier_damage_arbiter
// Serialises barrier-hit events from NUM_REQ shot sources onto the single
// damage port of the barrier block. Each source has a one-entry holding
// register. Hits whose y lies outside [BAND_YMIN, BAND_YMAX] are accepted
// and discarded, and counted in drop_cnt. A round-robin arbiter issues at
// most one new_damage pulse at a time. After each pulse it waits
// HOLD_CYCLES idle cycles, then one IDLE cycle, before it can issue again.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   restart    game restart, same effect as rst
//   bus        barrier_damage_if.slave (request handshake + damage outputs)
//   busy       FSM not IDLE, or any entry pending
//   drop_cnt   saturating count of out-of-band hits
//   state_dbg  current FSM state (0 IDLE, 1 ISSUE, 2 GAP)
module barrier_damage_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COORD_W     = 11,
  parameter int BAND_YMIN   = 340,
  parameter int BAND_YMAX   = 397,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  barrier_damage_if.slave      bus,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output logic [1:0]           state_dbg
);
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [COORD_W-1:0] YMIN = COORD_W'(BAND_YMIN);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(BAND_YMAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  pending;
  logic [COORD_W-1:0]  hx [NUM_REQ];
  logic [COORD_W-1:0]  hy [NUM_REQ];
  logic [ID_W-1:0]     rr_ptr;
  logic [GAP_W-1:0]    gap_cnt;

  logic [COORD_W-1:0]  cy [NUM_REQ];
  logic [NUM_REQ-1:0]  hs, cap_ok, cap_drop;
  logic [8:0]          drop_sum;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     sel;
  int                  idx;

  // No capture can happen on a rst/restart edge because ready is forced low.
  assign bus.req_ready = ~pending & {NUM_REQ{~(rst | restart)}};
  assign busy          = (state != IDLE) | (|pending);
  assign state_dbg     = state;

  // Capture decode and band filter.
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_REQ; i++) begin
      cy[i]       = bus.req_y[i*COORD_W +: COORD_W];
      hs[i]       = bus.req_valid[i] & bus.req_ready[i];
      cap_ok[i]   = hs[i] & (cy[i] >= YMIN) & (cy[i] <= YMAX);
      cap_drop[i] = hs[i] & ~((cy[i] >= YMIN) & (cy[i] <= YMAX));
      // Each simultaneous drop adds one, stopping at 255.
      if (cap_drop[i] && drop_sum != 9'd255) drop_sum = drop_sum + 9'd1;
    end
  end

  // Round-robin pick: the first pending entry at or after rr_ptr, with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && pending[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state          <= IDLE;
      pending        <= '0;
      rr_ptr         <= '0;
      gap_cnt        <= '0;
      drop_cnt       <= '0;
      bus.new_damage <= 1'b0;
      bus.damage_x   <= '0;
      bus.damage_y   <= '0;
      bus.grant_id   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hx[i] <= '0;
        hy[i] <= '0;
      end
    end else begin
      // A capture and a grant never touch the same entry on one edge:
      // a capture needs the entry empty, and a grant needs it full.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_ok[i]) begin
          pending[i] <= 1'b1;
          hx[i]      <= bus.req_x[i*COORD_W +: COORD_W];
          hy[i]      <= cy[i];
        end
      end
      drop_cnt <= drop_sum[7:0];

      case (state)
        IDLE: begin
          if (found) begin
            bus.damage_x   <= hx[win];
            bus.damage_y   <= hy[win];
            bus.grant_id   <= win;
            pending[win]   <= 1'b0;
            rr_ptr         <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            bus.new_damage <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.new_damage <= 1'b0;
          if (HOLD_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_W'(GAP_INIT);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          bus.new_damage <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_barrier_damage_arbiter.sv
// tb_barrier_damage_arbiter
// Directed bench for barrier_damage_arbiter. Instance dut uses
// HOLD_CYCLES=2. Instance dut0 uses HOLD_CYCLES=0 and shares clk/rst/restart.
module tb_barrier_damage_arbiter;
  localparam int NR = 4;
  localparam int CW = 11;
  localparam int IW = 2;
  localparam int PW = IW + 2 * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  barrier_damage_if #(.NUM_REQ(NR), .COORD_W(CW)) bus ();
  barrier_damage_if #(.NUM_REQ(NR), .COORD_W(CW)) bus0 ();
  logic       busy, busy0;
  logic [7:0] drop_cnt, drop_cnt0;
  logic [1:0] st, st0;

  barrier_damage_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .BAND_YMIN(340),
                           .BAND_YMAX(397), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .restart(restart), .bus(bus),
    .busy(busy), .drop_cnt(drop_cnt), .state_dbg(st)
  );

  barrier_damage_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .BAND_YMIN(340),
                           .BAND_YMAX(397), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .restart(restart), .bus(bus0),
    .busy(busy0), .drop_cnt(drop_cnt0), .state_dbg(st0)
  );

  // ---------------- monitor / scoreboard ----------------
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] got0_q[$];
  logic [PW-1:0] exp_q[$];
  int            cyc_q[$];
  int            cyc0_q[$];
  int            hs0_cnt = 0;

  always @(negedge clk) begin
    if (bus.new_damage) begin
      got_q.push_back({bus.grant_id, bus.damage_x, bus.damage_y});
      cyc_q.push_back(cyc);
    end
    if (bus0.new_damage) begin
      got0_q.push_back({bus0.grant_id, bus0.damage_x, bus0.damage_y});
      cyc0_q.push_back(cyc);
    end
    if (bus.req_valid[0] && bus.req_ready[0]) hs0_cnt <= hs0_cnt + 1;
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [CW-1:0] x,
                         input logic [CW-1:0] y);
    bus.req_valid[i]         = v;
    bus.req_x[i*CW +: CW]    = x;
    bus.req_y[i*CW +: CW]    = y;
  endtask

  task automatic send(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic done;
    done = 1'b0;
    set_req(i, 1'b1, x, y);
    for (int k = 0; k < 50; k++) begin
      if (bus.req_ready[i]) begin
        step(1);
        done = 1'b1;
        break;
      end
      step(1);
    end
    bus.req_valid[i] = 1'b0;
    chk("send_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      step(1);
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic push_exp(input int id, input int x, input int y);
    exp_q.push_back({IW'(id), CW'(x), CW'(y)});
  endtask

  task automatic check_pulses(input string tag, input int base);
    chk({tag, "_count"}, got_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < got_q.size())
        chk($sformatf("%s_pulse%0d", tag, k), got_q[base+k], exp_q[k]);
    end
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int base, base0, hs_base;

  initial begin
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus0.req_valid = '0;
    bus0.req_x     = '0;
    bus0.req_y     = '0;

    // Reset state.
    rst = 1'b1;
    step(2);
    chk("rst_ready_low", bus.req_ready, 0);
    chk("rst_new_damage", bus.new_damage, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_damage_x", bus.damage_x, 0);
    chk("rst_damage_y", bus.damage_y, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_state", st, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.req_ready, 4'hF);

    // Single hit from requester 1.
    base = got_q.size();
    set_req(1, 1'b1, 100, 350);
    step(1);                      // E0: capture
    bus.req_valid[1] = 1'b0;
    chk("single_ready_e0", bus.req_ready, 4'b1101);
    chk("single_busy_e0", busy, 1);
    chk("single_nd_e0", bus.new_damage, 0);
    step(1);                      // E1: grant
    chk("single_nd_e1", bus.new_damage, 1);
    chk("single_x", bus.damage_x, 100);
    chk("single_y", bus.damage_y, 350);
    chk("single_gid", bus.grant_id, 1);
    chk("single_ready_e1", bus.req_ready, 4'hF);
    chk("single_state_issue", st, 1);
    step(1);                      // E2: GAP
    chk("single_nd_e2", bus.new_damage, 0);
    chk("single_state_gap", st, 2);
    chk("single_busy_e2", busy, 1);
    step(1);                      // E3: GAP
    chk("single_busy_e3", busy, 1);
    step(1);                      // E4: IDLE
    chk("single_busy_e4", busy, 0);
    chk("single_x_hold", bus.damage_x, 100);
    chk("single_gid_hold", bus.grant_id, 1);
    push_exp(1, 100, 350);
    check_pulses("single", base);

    // Round-robin from rr_ptr=0.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    base = got_q.size();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, CW'(10 + i), CW'(350 + i));
    step(1);
    bus.req_valid = '0;
    step(16);
    wait_idle(20);
    for (int i = 0; i < NR; i++) push_exp(i, 10 + i, 350 + i);
    for (int k = 0; k < 3; k++) begin
      if (base + k + 1 < cyc_q.size())
        chk($sformatf("rr_spacing%0d", k), cyc_q[base+k+1] - cyc_q[base+k], 4);
    end
    check_pulses("rr0", base);

    // Move rr_ptr to 1, then repeat the burst.
    base = got_q.size();
    send(0, 7, 360);
    wait_idle(20);
    push_exp(0, 7, 360);
    check_pulses("rr_setup", base);
    base = got_q.size();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, CW'(20 + i), CW'(360 + i));
    step(1);
    bus.req_valid = '0;
    step(16);
    wait_idle(20);
    push_exp(1, 21, 361);
    push_exp(2, 22, 362);
    push_exp(3, 23, 363);
    push_exp(0, 20, 360);
    check_pulses("rr1", base);

    // Band filter boundaries.
    base = got_q.size();
    send(2, 50, 339);
    wait_idle(20);
    send(2, 51, 398);
    wait_idle(20);
    send(2, 52, 340);
    wait_idle(20);
    send(2, 53, 397);
    wait_idle(20);
    chk("band_drop_cnt", drop_cnt, 2);
    push_exp(2, 52, 340);
    push_exp(2, 53, 397);
    check_pulses("band", base);

    // drop_cnt saturation: 4 drops per cycle, 300 in total.
    base = got_q.size();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 0, 0);
    step(63);
    chk("drop_254", drop_cnt, 254);
    step(12);
    bus.req_valid = '0;
    chk("drop_sat", drop_cnt, 255);
    step(2);
    chk("drop_sat_hold", drop_cnt, 255);
    check_pulses("drop_none", base);

    // Backpressure: requester 0 holds valid for 10 edges.
    base = got_q.size();
    hs_base = hs0_cnt;
    set_req(0, 1'b1, 5, 360);
    step(1);                      // E0
    chk("bp_ready_low_e0", bus.req_ready[0], 0);
    step(1);                      // E1: grant
    chk("bp_ready_high_e1", bus.req_ready[0], 1);
    step(1);                      // E2: recapture
    chk("bp_ready_low_e2", bus.req_ready[0], 0);
    step(7);
    bus.req_valid[0] = 1'b0;
    wait_idle(20);
    step(1);
    chk("bp_handshakes", hs0_cnt - hs_base, 3);
    chk("bp_pulses_eq_hs", got_q.size() - base, hs0_cnt - hs_base);
    push_exp(0, 5, 360);
    push_exp(0, 5, 360);
    push_exp(0, 5, 360);
    check_pulses("bp", base);

    // Restart mid-GAP with requesters 2 and 3 pending (rr_ptr is 1).
    base = got_q.size();
    set_req(2, 1'b1, 200, 370);
    set_req(3, 1'b1, 300, 380);
    step(1);                      // E0
    bus.req_valid = '0;
    step(1);                      // E1: grant 2
    chk("rs_nd_e1", bus.new_damage, 1);
    chk("rs_gid_e1", bus.grant_id, 2);
    step(1);                      // E2: GAP
    chk("rs_state_gap", st, 2);
    restart = 1'b1;
    #1;
    chk("rs_ready_during", bus.req_ready, 0);
    step(1);                      // E3: restart edge
    restart = 1'b0;
    #1;
    chk("rs_nd", bus.new_damage, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", bus.req_ready, 4'hF);
    chk("rs_drop_cnt", drop_cnt, 0);
    chk("rs_damage_x", bus.damage_x, 0);
    chk("rs_grant_id", bus.grant_id, 0);
    chk("rs_state", st, 0);
    step(10);
    chk("rs_still_idle", busy, 0);
    push_exp(2, 200, 370);
    check_pulses("rs", base);

    // HOLD_CYCLES=0 instance: requesters 1 and 3 pending together.
    base0 = got0_q.size();
    bus0.req_valid[1]      = 1'b1;
    bus0.req_x[1*CW +: CW] = 11;
    bus0.req_y[1*CW +: CW] = 341;
    bus0.req_valid[3]      = 1'b1;
    bus0.req_x[3*CW +: CW] = 33;
    bus0.req_y[3*CW +: CW] = 396;
    step(1);
    bus0.req_valid = '0;
    step(6);
    chk("h0_count", got0_q.size() - base0, 2);
    if (got0_q.size() - base0 >= 2) begin
      chk("h0_pulse0", got0_q[base0], {2'd1, 11'd11, 11'd341});
      chk("h0_pulse1", got0_q[base0+1], {2'd3, 11'd33, 11'd396});
      chk("h0_spacing", cyc0_q[base0+1] - cyc0_q[base0], 2);
    end
    chk("h0_busy", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
